ic_hc_ac_table_arbiter: RTL and testbench
=========================================

Name: ic_hc_ac_table_arbiter

Overview:
- Shares one chroma AC Huffman table ROM (161 x 21-bit, 8-bit address, 1-cycle registered-address read) between two requesters: the Cb and Cr AC encoders.
- Maps each (run, size) symbol to a ROM address, or to the ZRL constant, and arbitrates round-robin.
- Tracks the ROM read latency and returns {code, length, id} in request order through a 2-entry output FIFO with valid/ready backpressure.

Parameters:
- NUM_WORDS, 161, ROM depth; index 160 holds EOB.
- FIFO_DEPTH, 2, output FIFO depth; also the outstanding-request credit limit.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  2  per-requester symbol valid (bit0 = Cb, bit1 = Cr)
- req_ready  out  2  per-requester accept; handshake when valid & ready on a rising edge
- req_run  in  8  {run1[3:0], run0[3:0]}
- req_size  in  8  {size1[3:0], size0[3:0]}
- rom_address  out  8  to table ROM address (combinational from granted request)
- rom_q  in  21  ROM data: [20:16] code length 1..16, [15:0] code right-aligned
- rsp_valid  out  1  response available
- rsp_ready  in  1  consumer accepts response
- rsp_id  out  1  requester that issued the symbol
- rsp_code  out  16  Huffman code, right-aligned
- rsp_len  out  5  code length; 0 = illegal symbol (optional feature only)
- err  out  1  sticky illegal-symbol flag

Behaviour:
- Reset: req_ready = 0, rsp_valid = 0, rsp_id/rsp_code/rsp_len = 0, err = 0, rom_address = 0, RR pointer = requester 0, FIFO and counters empty. Reset mid-operation discards in-flight lookups and FIFO contents.
- Address map:
  - size 1..10: run*10 + size - 1 (0..159).
  - run 0, size 0 (EOB): 160.
  - run 15, size 0 (ZRL): no ROM access; the package constant ZRL_CODE = 16'h03FA, ZRL_LEN = 10 is used.
  - Arithmetic in 8 bits; the maximum legal result is 159.
- Arbitration:
  - One grant per cycle.
  - If both requesters are valid, grant the one not granted last; the pointer updates only on a handshake.
  - A single valid requester is granted regardless of the pointer.
  - req_ready is asserted only for the granted requester and only when credit is available.
- Credit: outstanding = in-flight (0/1) + FIFO occupancy.
  - Issue allowed iff outstanding < FIFO_DEPTH, or outstanding == FIFO_DEPTH with a FIFO pop (rsp_valid & rsp_ready) in the same cycle.
  - Simultaneous issue and pop leaves the count unchanged.
- Pipeline:
  - Handshake at edge E0: the ROM samples rom_address; the in-flight flag is set with id and zrl bit.
  - During E0..E1, rom_q is valid.
  - At E1, the entry is pushed: length/code come from rom_q, or from the ZRL constants if the zrl bit is set.
  - rsp_valid is high from E1 when the FIFO was empty, giving 2-edge latency. Throughput is 1 symbol/cycle.
- FIFO: first-word-fall-through; order equals grant order.
  - Push and pop in the same cycle are legal at any occupancy reachable under the credit rule.
  - The credit rule guarantees no overflow; pop on empty cannot occur because rsp_valid = 0.
- rom_address holds its last value when no grant occurs.

Optional Feature:
- Macro: IC_HC_ARB_SIZE_CHECK_EN.
- Defined: a request is illegal if size > 10, or size == 0 with run not in {0, 15}.
  - An illegal request is still accepted and consumes a slot.
  - No ROM-dependent data is used; the response is pushed with rsp_len = 0, rsp_code = 0.
  - err is set and stays set until reset.
- Undefined: no check. err is tied 0. Illegal symbols produce whatever address the map arithmetic yields, with no guarantee on the response data.

Decomposition:
- Package ic_hc_pkg holds:
  - ZRL_CODE, ZRL_LEN, EOB_ADDR = 160, AC_SIZE_MAX = 10, ROM_W = 21, LEN_MSB = 20, LEN_LSB = 16.
  - The function ac_addr(run, size).
- One sub-module: ic_hc_rsp_fifo (parameterised FIFO_DEPTH x {id, len, code}, FWFT, count output).

Test Plan:
- Cb only, run=0 size=1, rsp_ready=1: rom_address = 0 on the handshake cycle; rsp_valid 2 edges later; rsp_len/rsp_code equal the ROM word at 0 (2, 16'h0001); rsp_id = 0.
- Both valid every cycle: Cb/Cr symbols (1,2) and (3,4) give addresses 11 and 33; grants alternate 0,1,0,1; responses return in grant order, one per cycle.
- Cr sends EOB (0,0), then ZRL (15,0), then (15,10): addresses 160, then none, then 159; responses are ROM[160], then {16'h03FA, 10}, then ROM[159].
- rsp_ready held 0: at most 2 handshakes, then req_ready = 0. After rsp_ready = 1, one pop frees a credit in the same cycle and no data is lost or duplicated.
- Reset asserted with 1 in flight and 2 in the FIFO: next cycle rsp_valid = 0, err = 0, RR favours Cb; a fresh request completes normally.
- With IC_HC_ARB_SIZE_CHECK_EN, Cb sends run=2 size=0: response has rsp_len = 0; err rises on the push edge and stays 1. Without the macro, err stays 0.

Source files
------------

// File: rtl/ic_hc_pkg.sv
// ---------------------------------------------------------------------------
// ic_hc_pkg
// Shared constants, response payload type and symbol helpers for the chroma
// AC Huffman table arbiter.
//   ZRL_CODE/ZRL_LEN : code used for run 15 / size 0 (no table access)
//   EOB_ADDR         : table index holding the end-of-block code
//   rsp_entry_t      : {id, len, code} response payload
//   ac_addr()        : (run, size) -> table index
// ---------------------------------------------------------------------------
package ic_hc_pkg;

    localparam int unsigned ROM_W    = 21;
    localparam int unsigned LEN_MSB  = 20;
    localparam int unsigned LEN_LSB  = 16;
    localparam int unsigned CODE_W   = 16;
    localparam int unsigned LEN_W    = 5;
    localparam int unsigned SYM_W    = 4;
    localparam int unsigned MAP_W    = 8;

    localparam logic [MAP_W-1:0]  EOB_ADDR    = 8'd160;
    localparam logic [SYM_W-1:0]  AC_SIZE_MAX = 4'd10;
    localparam logic [SYM_W-1:0]  ZRL_RUN     = 4'd15;
    localparam logic [CODE_W-1:0] ZRL_CODE    = 16'h03FA;
    localparam logic [LEN_W-1:0]  ZRL_LEN     = 5'd10;

    typedef struct packed {
        logic              id;
        logic [LEN_W-1:0]  len;
        logic [CODE_W-1:0] code;
    } rsp_entry_t;

    // Table index for a symbol; 8-bit wrap is intended for out-of-range input
    function automatic logic [MAP_W-1:0] ac_addr(input logic [SYM_W-1:0] run,
                                                 input logic [SYM_W-1:0] size);
        logic [MAP_W-1:0] run_w;
        logic [MAP_W-1:0] size_w;
        run_w  = MAP_W'(run);
        size_w = MAP_W'(size);
        if (run == '0 && size == '0) begin
            ac_addr = EOB_ADDR;
        end else begin
            ac_addr = run_w * 8'd10 + size_w - 8'd1;
        end
    endfunction

    function automatic logic is_zrl(input logic [SYM_W-1:0] run,
                                    input logic [SYM_W-1:0] size);
        return (run == ZRL_RUN) && (size == '0);
    endfunction

    // Size above the table range, or size 0 other than EOB/ZRL
    function automatic logic is_illegal(input logic [SYM_W-1:0] run,
                                        input logic [SYM_W-1:0] size);
        return (size > AC_SIZE_MAX) ||
               ((size == '0) && (run != '0) && (run != ZRL_RUN));
    endfunction

endpackage

// File: rtl/ic_hc_rsp_fifo.sv
// ---------------------------------------------------------------------------
// ic_hc_rsp_fifo
// First-word-fall-through response FIFO, FIFO_DEPTH x rsp_entry_t.
//   clock, reset : clock, synchronous active-high reset (clears contents)
//   push, push_data : write one entry
//   pop          : consume the head entry (ignored when empty)
//   head, valid  : head entry and non-empty flag
//   count        : current occupancy
// The owner guarantees no push when full without a simultaneous pop.
// ---------------------------------------------------------------------------
module ic_hc_rsp_fifo
    import ic_hc_pkg::*;
#(
    parameter int unsigned  FIFO_DEPTH = 2,
    localparam int unsigned PTR_W      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1,
    localparam int unsigned CNT_W      = $clog2(FIFO_DEPTH + 1)
)(
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  rsp_entry_t       push_data,
    input  logic             pop,
    output rsp_entry_t       head,
    output logic             valid,
    output logic [CNT_W-1:0] count
);

    rsp_entry_t       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             pop_ok;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign pop_ok = pop && valid;

    // Storage, pointers and occupancy
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (pop_ok) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({push, pop_ok})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign head  = mem[rd_ptr];
    assign valid = (count != '0);

endmodule

// File: rtl/ic_hc_ac_table_arbiter.sv
// ---------------------------------------------------------------------------
// ic_hc_ac_table_arbiter
// Shares one chroma AC Huffman table ROM (registered-address, 1-cycle read)
// between the Cb (id 0) and Cr (id 1) AC encoders. Symbols are mapped to a
// table index (ZRL bypasses the table), granted round-robin under a credit
// limit of FIFO_DEPTH outstanding lookups, and returned in grant order.
//   clock, reset        : clock, synchronous active-high reset
//   req_valid/req_ready : per-requester handshake (bit0 Cb, bit1 Cr)
//   req_run, req_size   : {req1[3:0], req0[3:0]} symbol fields
//   rom_address, rom_q  : table ROM port (address combinational from grant)
//   rsp_valid/rsp_ready : response handshake
//   rsp_id/code/len     : response payload
//   err                 : sticky illegal-symbol flag
// Optional: define IC_HC_ARB_SIZE_CHECK_EN to flag illegal symbols, which
// then return len 0 / code 0 and set err. Undefined: err is tied 0.
// ---------------------------------------------------------------------------
module ic_hc_ac_table_arbiter
    import ic_hc_pkg::*;
#(
    parameter int unsigned  NUM_WORDS  = 161,
    parameter int unsigned  FIFO_DEPTH = 2,
    localparam int unsigned RA_W       = $clog2(NUM_WORDS),
    localparam int unsigned CNT_W      = $clog2(FIFO_DEPTH + 1)
)(
    input  logic              clock,
    input  logic              reset,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [7:0]        req_run,
    input  logic [7:0]        req_size,
    output logic [RA_W-1:0]   rom_address,
    input  logic [ROM_W-1:0]  rom_q,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [CODE_W-1:0] rsp_code,
    output logic [LEN_W-1:0]  rsp_len,
    output logic              err
);

    localparam int unsigned OUT_W = CNT_W + 1;

    logic             rr_prio;       // requester favoured when both are valid
    logic             inflight;      // lookup whose ROM data is on rom_q now
    logic             inflight_id;
    logic             inflight_zrl;
    logic [RA_W-1:0]  addr_q;        // last address presented to the ROM

    logic             any_valid;
    logic             grant_id;
    logic             issue_ok;
    logic             issue;
    logic             pop;
    logic [OUT_W-1:0] outstanding;
    logic [SYM_W-1:0] sel_run;
    logic [SYM_W-1:0] sel_size;
    logic             sel_zrl;
    logic [RA_W-1:0]  sel_addr;

    logic [CNT_W-1:0] fifo_count;
    rsp_entry_t       push_data;
    rsp_entry_t       head;

    assign pop = rsp_valid && rsp_ready;

    // Round-robin grant, credit check and symbol-to-address mapping
    always_comb begin
        req_ready   = 2'b00;
        any_valid   = |req_valid;
        grant_id    = (req_valid == 2'b11) ? rr_prio : req_valid[1];
        outstanding = OUT_W'(fifo_count) + OUT_W'(inflight);
        issue_ok    = (outstanding < OUT_W'(FIFO_DEPTH)) ||
                      ((outstanding == OUT_W'(FIFO_DEPTH)) && pop);
        if (any_valid && issue_ok && !reset) begin
            req_ready[grant_id] = 1'b1;
        end
        issue    = |(req_valid & req_ready);
        sel_run  = grant_id ? req_run[7:4]  : req_run[3:0];
        sel_size = grant_id ? req_size[7:4] : req_size[3:0];
        sel_zrl  = is_zrl(sel_run, sel_size);
        sel_addr = RA_W'(ac_addr(sel_run, sel_size));
        // ZRL never touches the table, so the address is left unchanged
        rom_address = (issue && !sel_zrl) ? sel_addr : addr_q;
    end

    // Grant pointer, address hold and in-flight tracking
    always_ff @(posedge clock) begin
        if (reset) begin
            rr_prio      <= 1'b0;
            inflight     <= 1'b0;
            inflight_id  <= 1'b0;
            inflight_zrl <= 1'b0;
            addr_q       <= '0;
        end else begin
            inflight <= issue;
            if (issue) begin
                rr_prio      <= ~grant_id;
                inflight_id  <= grant_id;
                inflight_zrl <= sel_zrl;
            end
            if (issue && !sel_zrl) begin
                addr_q <= sel_addr;
            end
        end
    end

`ifdef IC_HC_ARB_SIZE_CHECK_EN
    logic inflight_bad;
    logic err_q;

    // Illegal-symbol tracking; err rises when the bad entry is pushed
    always_ff @(posedge clock) begin
        if (reset) begin
            inflight_bad <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            if (issue) begin
                inflight_bad <= is_illegal(sel_run, sel_size);
            end
            if (inflight && inflight_bad) begin
                err_q <= 1'b1;
            end
        end
    end

    assign err = err_q;

    // Entry pushed on the edge after the grant, while rom_q holds its word
    always_comb begin
        push_data.id   = inflight_id;
        push_data.len  = rom_q[LEN_MSB:LEN_LSB];
        push_data.code = rom_q[CODE_W-1:0];
        if (inflight_zrl) begin
            push_data.len  = ZRL_LEN;
            push_data.code = ZRL_CODE;
        end else if (inflight_bad) begin
            push_data.len  = '0;
            push_data.code = '0;
        end
    end
`else
    assign err = 1'b0;

    // Entry pushed on the edge after the grant, while rom_q holds its word
    always_comb begin
        push_data.id   = inflight_id;
        push_data.len  = rom_q[LEN_MSB:LEN_LSB];
        push_data.code = rom_q[CODE_W-1:0];
        if (inflight_zrl) begin
            push_data.len  = ZRL_LEN;
            push_data.code = ZRL_CODE;
        end
    end
`endif

    ic_hc_rsp_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_rsp_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (inflight),
        .push_data (push_data),
        .pop       (pop),
        .head      (head),
        .valid     (rsp_valid),
        .count     (fifo_count)
    );

    assign rsp_id   = head.id;
    assign rsp_len  = head.len;
    assign rsp_code = head.code;

endmodule

// File: tb/tb_ic_hc_ac_table_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ic_hc_ac_table_arbiter
// Scoreboard bench: a reference model predicts grants, credit, addresses and
// responses from the symbol rules; a negedge monitor compares every cycle.
// Build with IC_HC_ARB_SIZE_CHECK_EN defined to exercise the size check.
// ---------------------------------------------------------------------------
module tb_ic_hc_ac_table_arbiter;
    import ic_hc_pkg::*;

    localparam int NW    = 161;
    localparam int DEPTH = 2;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  req_valid = 2'b00;
    logic [1:0]  req_ready;
    logic [7:0]  req_run = 8'h00;
    logic [7:0]  req_size = 8'h00;
    logic [7:0]  rom_address;
    logic [20:0] rom_q = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic        rsp_id;
    logic [15:0] rsp_code;
    logic [4:0]  rsp_len;
    logic        err;

    ic_hc_ac_table_arbiter #(
        .NUM_WORDS  (NW),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_run     (req_run),
        .req_size    (req_size),
        .rom_address (rom_address),
        .rom_q       (rom_q),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_id      (rsp_id),
        .rsp_code    (rsp_code),
        .rsp_len     (rsp_len),
        .err         (err)
    );

    always #5 clock = ~clock;

    // Table ROM with registered address
    logic [20:0] rom_mem [NW];
    always @(posedge clock) begin
        if (!$isunknown(rom_address) && int'(rom_address) < NW)
            rom_q <= rom_mem[rom_address];
        else
            rom_q <= '0;
    end

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge clock) cyc++;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h cycle=%0d", nm, act, exp, cyc);
        end
    endtask

    // ---------------- reference model / scoreboard ----------------
    typedef struct {
        logic        id;
        logic [4:0]  len;
        logic [15:0] code;
        bit          dc;       // data unspecified (illegal, no check)
        int          rdy_cyc;  // first monitor cycle it should be visible
    } exp_t;

    exp_t sbq[$];
    int   out_m       = 0;
    bit   rr_m        = 1'b0;
    int   last_addr_m = 0;
    bit   last_known  = 1'b1;
    int   err_cyc_m   = -1;
    bit   prev_rst    = 1'b0;

    always @(negedge clock) begin : monitor
        bit         exp_v, pop_m, exp_err, g, zrl, legal;
        logic [1:0] exp_rdy;
        int         run, size, addr;
        exp_t       e;
        if (reset) begin
            chk("ready_in_reset", 32'(req_ready), 32'd0);
            if (prev_rst) begin
                chk("rsp_valid_after_reset", 32'(rsp_valid), 32'd0);
                chk("err_after_reset", 32'(err), 32'd0);
            end
            sbq.delete();
            out_m = 0; rr_m = 1'b0; last_addr_m = 0; last_known = 1'b1; err_cyc_m = -1;
            prev_rst = 1'b1;
        end else begin
            prev_rst = 1'b0;
            exp_v = (sbq.size() > 0) && (sbq[0].rdy_cyc <= cyc);
            chk("rsp_valid", 32'(rsp_valid), 32'(exp_v));
            pop_m = exp_v && rsp_ready;
            if (exp_v) begin
                chk("rsp_id", 32'(rsp_id), 32'(sbq[0].id));
                if (!sbq[0].dc) begin
                    chk("rsp_len", 32'(rsp_len), 32'(sbq[0].len));
                    chk("rsp_code", 32'(rsp_code), 32'(sbq[0].code));
                end
            end
`ifdef IC_HC_ARB_SIZE_CHECK_EN
            exp_err = (err_cyc_m >= 0) && (cyc >= err_cyc_m);
`else
            exp_err = 1'b0;
`endif
            chk("err", 32'(err), 32'(exp_err));

            exp_rdy = 2'b00;
            g = 1'b0;
            if (req_valid != 2'b00 && (out_m < DEPTH || (out_m == DEPTH && pop_m))) begin
                g = (req_valid == 2'b11) ? rr_m : req_valid[1];
                exp_rdy[g] = 1'b1;
            end
            chk("req_ready", 32'(req_ready), 32'(exp_rdy));

            if (exp_rdy != 2'b00) begin
                run   = g ? int'(req_run[7:4])  : int'(req_run[3:0]);
                size  = g ? int'(req_size[7:4]) : int'(req_size[3:0]);
                zrl   = (run == 15) && (size == 0);
                legal = (size >= 1 && size <= 10) || (size == 0 && run == 0);
                addr  = (size == 0) ? 160 : run * 10 + size - 1;
                e.id = g; e.dc = 1'b0; e.rdy_cyc = cyc + 2;
                if (zrl) begin
                    e.len = 5'd10; e.code = 16'h03FA;
                    if (last_known) chk("rom_address_hold_zrl", 32'(rom_address), 32'(last_addr_m));
                end else if (legal) begin
                    e.len = rom_mem[addr][20:16]; e.code = rom_mem[addr][15:0];
                    chk("rom_address", 32'(rom_address), 32'(addr));
                    last_addr_m = addr; last_known = 1'b1;
                end else begin
`ifdef IC_HC_ARB_SIZE_CHECK_EN
                    e.len = 5'd0; e.code = 16'h0000;
                    if (err_cyc_m < 0) err_cyc_m = cyc + 2;
`else
                    e.len = 'x; e.code = 'x; e.dc = 1'b1;
`endif
                    last_known = 1'b0;
                end
                sbq.push_back(e);
                rr_m = ~g;
                out_m++;
            end else if (last_known) begin
                chk("rom_address_idle", 32'(rom_address), 32'(last_addr_m));
            end
            if (pop_m) begin
                void'(sbq.pop_front());
                out_m--;
            end
        end
    end

    // ---------------- stimulus ----------------
    typedef struct { logic [3:0] run; logic [3:0] size; } sym_t;
    sym_t src0[$];
    sym_t src1[$];
    int   gap_pct   = 0;
    int   ready_pct = 100;

    function automatic sym_t mk(input int r, input int s);
        sym_t x;
        x.run = 4'(r); x.size = 4'(s);
        return x;
    endfunction

    function automatic sym_t rand_sym();
        int k;
        k = int'($urandom_range(0, 15));
        if (k == 0)      return mk(0, 0);
        else if (k == 1) return mk(15, 0);
        else if (k == 2) return mk(int'($urandom_range(0, 15)), int'($urandom_range(11, 15)));
        else if (k == 3) return mk(int'($urandom_range(1, 14)), 0);
        else             return mk(int'($urandom_range(0, 15)), int'($urandom_range(1, 10)));
    endfunction

    // One clock of driving; entered and left at posedge + 1
    task automatic drive_cycle();
        logic [1:0] acc;
        req_run   = 8'($urandom_range(0, 255));
        req_size  = 8'($urandom_range(0, 255));
        req_valid = 2'b00;
        if (src0.size() > 0 && int'($urandom_range(0, 99)) >= gap_pct) begin
            req_valid[0] = 1'b1; req_run[3:0] = src0[0].run; req_size[3:0] = src0[0].size;
        end
        if (src1.size() > 0 && int'($urandom_range(0, 99)) >= gap_pct) begin
            req_valid[1] = 1'b1; req_run[7:4] = src1[0].run; req_size[7:4] = src1[0].size;
        end
        rsp_ready = (int'($urandom_range(0, 99)) < ready_pct);
        @(negedge clock);
        acc = req_valid & req_ready;
        @(posedge clock);
        #1;
        if (acc[0]) void'(src0.pop_front());
        if (acc[1]) void'(src1.pop_front());
    endtask

    task automatic drain(input int max_cycles);
        int n;
        n = 0;
        while ((src0.size() > 0 || src1.size() > 0 || sbq.size() > 0) && n < max_cycles) begin
            drive_cycle();
            n++;
        end
        checks++;
        if (src0.size() > 0 || src1.size() > 0 || sbq.size() > 0) begin
            errors++;
            $display("FAIL drain_timeout actual=%0d pending required=0 pending cycle=%0d",
                     src0.size() + src1.size() + sbq.size(), cyc);
        end
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        req_valid = 2'b00;
        src0.delete();
        src1.delete();
        repeat (n) @(posedge clock);
        #1 reset = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < NW; i++)
            rom_mem[i] = {5'((i % 16) + 1), 16'((i * 40503 + 7) & 16'hFFFF)};
        rom_mem[0] = {5'd2, 16'h0001};

        repeat (3) @(posedge clock);
        #1 reset = 1'b0;

        // Single Cb lookup, address 0
        gap_pct = 0; ready_pct = 100;
        src0.push_back(mk(0, 1));
        drain(20);

        // Both requesters every cycle: alternating grants
        for (int i = 0; i < 4; i++) begin
            src0.push_back(mk(1, 2));
            src1.push_back(mk(3, 4));
        end
        drain(40);

        // Cr: EOB, ZRL, last table entry
        src1.push_back(mk(0, 0));
        src1.push_back(mk(15, 0));
        src1.push_back(mk(15, 10));
        drain(20);

        // Backpressure: credit limit, then release
        ready_pct = 0;
        for (int i = 0; i < 3; i++) begin
            src0.push_back(mk(i, 5));
            src1.push_back(mk(i + 4, 7));
        end
        repeat (8) drive_cycle();
        ready_pct = 100;
        drain(40);

        // Reset with lookups outstanding, then fresh requests
        ready_pct = 0;
        src0.push_back(mk(2, 3)); src0.push_back(mk(4, 4));
        src1.push_back(mk(5, 5));
        repeat (4) drive_cycle();
        do_reset(2);
        ready_pct = 100;
        src0.push_back(mk(1, 1));
        src1.push_back(mk(2, 2));
        drain(20);

        // Illegal symbol from Cb
        src0.push_back(mk(2, 0));
        src0.push_back(mk(6, 6));
        drain(20);

        // Randomized traffic
        gap_pct = 30; ready_pct = 70;
        for (int i = 0; i < 400; i++) begin
            if (src0.size() < 3) src0.push_back(rand_sym());
            if (src1.size() < 3) src1.push_back(rand_sym());
            drive_cycle();
        end
        ready_pct = 100;
        drain(200);

        do_reset(2);
        repeat (3) drive_cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog actual=running required=finished cycle=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
